// File: rtl/fproc_pkg.sv
// Shared defaults and per-port state encoding for the measurement function processor.
package fproc_pkg;
    localparam int DEF_NUM_CORES  = 4;
    localparam int DEF_NUM_MEAS   = 4;
    localparam int DEF_ID_WIDTH   = 8;
    localparam int DEF_DATA_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
endpackage

// File: rtl/fproc_port.sv
// One core's request port: latch an id, wait for that channel's result, strobe it back.
module fproc_port
    import fproc_pkg::*;
#(
    parameter int NUM_MEAS   = DEF_NUM_MEAS,
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [ID_WIDTH-1:0]   id,
    input  logic [NUM_MEAS-1:0]   meas,
    input  logic [NUM_MEAS-1:0]   meas_valid,
    input  logic [NUM_MEAS-1:0]   res,
    input  logic [NUM_MEAS-1:0]   fresh,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] data,
    output logic [NUM_MEAS-1:0]   consume
);
    logic [1:0]          state;
    logic [ID_WIDTH-1:0] id_q;
    logic [NUM_MEAS-1:0] hit;
    logic                in_range;
    logic                avail;
    logic                sel_bit;

    // hit is one-hot on the requested channel, all-zero when id_q is out of range
    always_comb begin
        hit = '0;
        for (int k = 0; k < NUM_MEAS; k++)
            hit[k] = (32'(id_q) == 32'(k));
        in_range = 32'(id_q) < 32'(NUM_MEAS);
        avail    = |(hit & (fresh | meas_valid));
        sel_bit  = |(hit & meas_valid) ? |(hit & meas) : |(hit & res);
        consume  = (state == ST_WAIT && avail) ? hit : '0;
    end

    assign ready = (state == ST_RESP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            id_q  <= '0;
            data  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (enable) begin
                    id_q  <= id;
                    state <= ST_WAIT;
                end
                ST_WAIT: if (!in_range) begin
                    data  <= '0;
                    state <= ST_RESP;
                end else if (avail) begin
                    data  <= {{(DATA_WIDTH-1){1'b0}}, sel_bit};
                    state <= ST_RESP;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/fproc_meas.sv
// Measurement result registers shared by NUM_CORES independent request ports.
module fproc_meas
    import fproc_pkg::*;
#(
    parameter int NUM_CORES  = DEF_NUM_CORES,
    parameter int NUM_MEAS   = DEF_NUM_MEAS,
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            fproc_enable,
    input  logic [NUM_CORES*ID_WIDTH-1:0]   fproc_id,
    input  logic [NUM_MEAS-1:0]             meas,
    input  logic [NUM_MEAS-1:0]             meas_valid,
    output logic [NUM_CORES-1:0]            fproc_ready,
    output logic [NUM_CORES*DATA_WIDTH-1:0] fproc_data
);
    logic [NUM_MEAS-1:0]                 res;
    logic [NUM_MEAS-1:0]                 fresh;
    logic [NUM_MEAS-1:0]                 consume;
    logic [NUM_CORES-1:0][NUM_MEAS-1:0]  port_consume;

    always_comb begin
        consume = '0;
        for (int c = 0; c < NUM_CORES; c++)
            consume |= port_consume[c];
    end

    // A consumed channel goes stale even if a new result lands on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            res   <= '0;
            fresh <= '0;
        end else begin
            res   <= (meas_valid & meas) | (~meas_valid & res);
            fresh <= (fresh | meas_valid) & ~consume;
        end
    end

    for (genvar c = 0; c < NUM_CORES; c++) begin : g_port
        fproc_port #(
            .NUM_MEAS   (NUM_MEAS),
            .ID_WIDTH   (ID_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_port (
            .clk        (clk),
            .reset      (reset),
            .enable     (fproc_enable[c]),
            .id         (fproc_id[c*ID_WIDTH +: ID_WIDTH]),
            .meas       (meas),
            .meas_valid (meas_valid),
            .res        (res),
            .fresh      (fresh),
            .ready      (fproc_ready[c]),
            .data       (fproc_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .consume    (port_consume[c])
        );
    end
endmodule

// File: tb/tb_fproc_meas.sv
// Scoreboard bench for fproc_meas: directed scenarios then randomized traffic.
module tb_fproc_meas;
    localparam int NC = 4;
    localparam int NM = 4;
    localparam int IW = 8;
    localparam int DW = 32;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     fproc_enable;
    logic [NC*IW-1:0]  fproc_id;
    logic [NM-1:0]     meas;
    logic [NM-1:0]     meas_valid;
    logic [NC-1:0]     fproc_ready;
    logic [NC*DW-1:0]  fproc_data;

    fproc_meas #(.NUM_CORES(NC), .NUM_MEAS(NM), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .fproc_enable (fproc_enable),
        .fproc_id     (fproc_id),
        .meas         (meas),
        .meas_valid   (meas_valid),
        .fproc_ready  (fproc_ready),
        .fproc_data   (fproc_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    bit mon_en = 0;

    // stimulus for the next cycle
    logic          s_rst;
    logic [NC-1:0] s_en;
    logic [IW-1:0] s_id [NC];
    logic [NM-1:0] s_mv;
    logic [NM-1:0] s_m;

    // reference model: pending request per core, latest result and freshness per channel
    bit          m_pend [NC];
    bit          m_resp [NC];
    int          m_pid  [NC];
    bit          m_res  [NM];
    bit          m_fresh[NM];
    logic [31:0] m_hold [NC];
    logic [31:0] hold_vis [NC];
    exp_t        exp_q [NC][$];

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        for (int c = 0; c < NC; c++) hold_vis[c] <= m_hold[c];
    end

    // Predict what the coming clock edge does to every port and channel.
    task automatic model_step();
        bit [NM-1:0] used;
        used = '0;
        if (s_rst) begin
            for (int c = 0; c < NC; c++) begin
                m_pend[c] = 0; m_resp[c] = 0; m_pid[c] = 0; m_hold[c] = '0;
            end
            for (int k = 0; k < NM; k++) begin
                m_res[k] = 0; m_fresh[k] = 0;
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                if (m_pend[c]) begin
                    bit go;
                    logic [31:0] d;
                    go = 0; d = '0;
                    if (m_pid[c] >= NM) begin
                        go = 1;
                    end else if (m_fresh[m_pid[c]] || s_mv[m_pid[c]]) begin
                        go = 1;
                        d  = {31'd0, s_mv[m_pid[c]] ? s_m[m_pid[c]] : m_res[m_pid[c]]};
                        used[m_pid[c]] = 1'b1;
                    end
                    if (go) begin
                        exp_q[c].push_back('{edge_cnt + 1, d});
                        m_hold[c] = d;
                        m_pend[c] = 0;
                        m_resp[c] = 1;
                    end
                end else if (m_resp[c]) begin
                    m_resp[c] = 0;
                end else if (s_en[c]) begin
                    m_pend[c] = 1;
                    m_pid[c]  = int'(s_id[c]);
                end
            end
            for (int k = 0; k < NM; k++) begin
                if (s_mv[k]) begin
                    m_res[k]   = s_m[k];
                    m_fresh[k] = 1;
                end
                if (used[k]) m_fresh[k] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        reset        = s_rst;
        fproc_enable = s_en;
        for (int c = 0; c < NC; c++) fproc_id[c*IW +: IW] = s_id[c];
        meas_valid   = s_mv;
        meas         = s_m;
        model_step();
        s_rst = 0; s_en = '0; s_mv = '0; s_m = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        s_rst = 1; tick();
    endtask

    // Monitor: every port, every cycle, against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < NC; c++) begin
                tests++;
                if (fproc_ready[c]) begin
                    if (exp_q[c].size() == 0) begin
                        fails++;
                        $display("FAIL ready_unexpected core%0d cyc=%0d got ready=1 want 0", c, edge_cnt);
                    end else begin
                        exp_t e;
                        e = exp_q[c].pop_front();
                        if (e.cyc != edge_cnt || fproc_data[c*DW +: DW] != e.data) begin
                            fails++;
                            $display("FAIL response core%0d got cyc=%0d data=%h want cyc=%0d data=%h",
                                     c, edge_cnt, fproc_data[c*DW +: DW], e.cyc, e.data);
                        end
                    end
                end else if (exp_q[c].size() > 0 && exp_q[c][0].cyc <= edge_cnt) begin
                    exp_t e;
                    e = exp_q[c].pop_front();
                    fails++;
                    $display("FAIL ready_missing core%0d got ready=0 at cyc=%0d want ready=1 data=%h", c, edge_cnt, e.data);
                end
                tests++;
                if (fproc_data[c*DW +: DW] !== hold_vis[c]) begin
                    fails++;
                    $display("FAIL data_hold core%0d cyc=%0d got %h want %h", c, edge_cnt, fproc_data[c*DW +: DW], hold_vis[c]);
                end
            end
        end
    end

    initial begin
        reset = 1; fproc_enable = '0; fproc_id = '0; meas = '0; meas_valid = '0;
        s_rst = 0; s_en = '0; s_mv = '0; s_m = '0;
        for (int c = 0; c < NC; c++) begin
            s_id[c] = '0; m_pend[c] = 0; m_resp[c] = 0; m_pid[c] = 0; m_hold[c] = '0;
        end
        for (int k = 0; k < NM; k++) begin
            m_res[k] = 0; m_fresh[k] = 0;
        end
        do_reset();
        do_reset();
        mon_en = 1;
        idle(2);

        // out-of-range id right after reset; second enable while busy is ignored
        do_reset();
        s_en[3] = 1; s_id[3] = 8'd200; tick();
        s_en[3] = 1; s_id[3] = 8'd5;   tick();
        idle(4);

        // fresh result consumed by core0, then core1 must wait for a new one
        do_reset();
        s_mv[1] = 1; s_m[1] = 1; tick();
        idle(1);
        s_en[0] = 1; s_id[0] = 8'd1; tick();
        idle(3);
        s_en[1] = 1; s_id[1] = 8'd1; tick();
        idle(4);
        s_mv[1] = 1; s_m[1] = 0; tick();
        idle(3);

        // long wait, served by bypass
        do_reset();
        s_en[2] = 1; s_id[2] = 8'd3; tick();
        idle(10);
        s_mv[3] = 1; s_m[3] = 0; tick();
        idle(3);

        // two cores on the same channel, then a third finds it stale
        do_reset();
        s_en[0] = 1; s_id[0] = 8'd0; s_en[1] = 1; s_id[1] = 8'd0; tick();
        idle(3);
        s_mv[0] = 1; s_m[0] = 1; tick();
        s_en[2] = 1; s_id[2] = 8'd0; tick();
        idle(5);

        // reset while waiting kills the request
        do_reset();
        s_en[0] = 1; s_id[0] = 8'd2; tick();
        idle(2);
        do_reset();
        s_mv[2] = 1; s_m[2] = 1; tick();
        idle(4);

        // latest result wins with no consumer
        do_reset();
        s_mv[0] = 1; s_m[0] = 1; tick();
        s_mv[0] = 1; s_m[0] = 0; tick();
        s_en[0] = 1; s_id[0] = 8'd0; tick();
        idle(4);

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < NC; c++) begin
                s_en[c] = ($urandom_range(0, 3) == 0);
                s_id[c] = ($urandom_range(0, 15) == 0) ? IW'($urandom_range(4, 255)) : IW'($urandom_range(0, 3));
            end
            for (int k = 0; k < NM; k++) s_mv[k] = ($urandom_range(0, 6) == 0);
            s_m   = NM'($urandom);
            s_rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        idle(6);

        for (int c = 0; c < NC; c++) begin
            tests++;
            if (exp_q[c].size() != 0) begin
                fails++;
                $display("FAIL drain core%0d got %0d outstanding responses want 0", c, exp_q[c].size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fproc_meas.md
FPROC_MEAS -- requirements
Module: fproc_meas

Interface
REQ-001 Parameter NUM_CORES, default 4, number of processor cores served.
REQ-002 Parameter NUM_MEAS, default 4, number of measurement channels.
REQ-003 Parameter ID_WIDTH, default 8, width of a core's function ID.
REQ-004 Parameter DATA_WIDTH, default 32, width of the returned data word.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 fproc_enable  input  NUM_CORES  per-core request strobe, one cycle, driven from the core's fproc_out_ready.
REQ-008 fproc_id  input  NUM_CORES*ID_WIDTH  per-core function ID, sampled with fproc_enable.
REQ-009 meas  input  NUM_MEAS  per-channel measurement result bit.
REQ-010 meas_valid  input  NUM_MEAS  per-channel one-cycle strobe qualifying meas.
REQ-011 fproc_ready  output  NUM_CORES  per-core response strobe, one cycle, to the core's fproc_ready.
REQ-012 fproc_data  output  NUM_CORES*DATA_WIDTH  per-core response word; meas bit zero-extended to DATA_WIDTH.

Function
REQ-013 Each channel k SHALL hold result register res[k] and flag fresh[k]; meas_valid[k] loads res[k]<=meas[k] and sets fresh[k].
REQ-014 Each core port SHALL run FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-015 IDLE: fproc_enable[c]=1 at edge t latches id into id_q and enters WAIT at t+1; otherwise stays in IDLE.
REQ-016 fproc_enable[c] asserted while the port is in WAIT or RESP SHALL be ignored and SHALL NOT alter id_q.
REQ-017 WAIT with id_q<NUM_MEAS: the data is available when fresh[id_q]=1 or meas_valid[id_q]=1 in the current cycle; while unavailable, stay in WAIT indefinitely.
REQ-018 WAIT with data available: enter RESP next edge; fproc_ready[c]=1 for that cycle only; fproc_data[c] = meas[id_q] if meas_valid[id_q], else res[id_q].
REQ-019 WAIT with id_q>=NUM_MEAS: enter RESP next edge with fproc_data[c]=0.
REQ-020 Minimum latency: request at edge t -> fproc_ready high in cycle t+2.
REQ-021 fproc_data[c] SHALL be registered and held stable from RESP until that port's next RESP.
REQ-022 fresh[k] SHALL clear on any edge where one or more ports leave WAIT consuming channel k, including when meas_valid[k] is also high that cycle (consumed bypass).
REQ-023 All ports waiting on the same channel in the same cycle SHALL be served on the same edge with identical data.
REQ-024 A port entering WAIT on the edge where fresh[k] clears SHALL wait for the next meas_valid[k].
REQ-025 meas_valid[k] with no waiting consumer SHALL overwrite res[k]; fresh[k] remains set (latest result wins, no queueing).
REQ-026 Ports SHALL be fully independent: no arbitration and no cross-port stalls.

Reset
REQ-027 While reset is high at an edge: all ports to IDLE, fproc_ready=0, fproc_data=0, id_q=0, res=0, fresh=0.
REQ-028 Reset SHALL override every in-flight WAIT/RESP and any concurrent fproc_enable or meas_valid.
REQ-029 fproc_enable in the first cycle after reset deasserts SHALL be accepted normally.

Structure
REQ-030 Shared package fproc_pkg SHALL hold the port-state encoding (IDLE, WAIT, RESP) and the default parameter values.
REQ-031 Per-core logic SHALL be one sub-module, fproc_port, instantiated NUM_CORES times; channel registers and fresh-clear reduction SHALL live in the top.

Verification
REQ-032 meas_valid[1]=1 with meas[1]=1; core0 requests id=1 two cycles later -> fproc_ready[0] exactly 2 cycles after request, data=0x00000001, fresh[1] cleared.
REQ-033 Core2 requests id=3 with fresh[3]=0; wait 10 cycles, then meas_valid[3]=1 with meas[3]=0 -> fproc_ready[2] on the next cycle, data=0, no earlier pulse.
REQ-034 Cores 0 and 1 both waiting on id=0; meas_valid[0]=1 with meas[0]=1 -> both ready strobes on the same cycle, both data=1, fresh[0]=0 afterward.
REQ-035 Core3 requests id=200 -> fproc_ready[3] two cycles later, data=0; a second fproc_enable during WAIT is ignored (exactly one pulse).
REQ-036 Core0 in WAIT on id=2; assert reset one cycle, then meas_valid[2]=1 -> no fproc_ready[0]; all outputs 0.
REQ-037 Two meas_valid[0] strobes (meas 1 then 0) with no consumer, then request id=0 -> data=0.
